irq_ctrl: RTL and testbench

Memory-mapped interrupt controller between the CPU and the interrupt-producing devices (timers and other peripherals) on the device bus. It latches up to six source lines into a pending register, applies a software mask, and selects the lowest-numbered active source. It presents that source to the CPU through a req/ack handshake and holds it in service until software writes end-of-interrupt (EOI).

---
 rtl/irq_ctrl.sv | 126 ++++++++++++
 tb/tb_irq_ctrl.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// Memory-mapped six-source interrupt controller with mask, pending register and req/ack/EOI handshake.
// Define IRQ_CTRL_EDGE_EN for rising-edge capture of src_irq; otherwise sources are level-captured.
module irq_ctrl #(
    parameter logic [31:0] BASE = 32'h00007f20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        write_enable,
    input  logic [31:0] write_data,
    output logic [31:0] read_result,
    input  logic [5:0]  src_irq,
    output logic        int_req,
    output logic [2:0]  int_id,
    input  logic        int_ack
);

    typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;

    state_t      state;
    logic [5:0]  mask;
    logic [5:0]  pending;
    logic [5:0]  active;
    logic [5:0]  set_bits;
    logic [5:0]  clr_bits;
    logic [5:0]  ack_clr;
    logic [31:0] offset;
    logic        wr_mask;
    logic        wr_w1c;
    logic        wr_eoi;
    logic [2:0]  sel;
    logic        unused_bits;

    assign offset      = addr - BASE;
    assign wr_mask     = write_enable && (offset == 32'h0);
    assign wr_w1c      = write_enable && (offset == 32'h4);
    assign wr_eoi      = write_enable && (offset == 32'hC);
    assign active      = pending & mask;
    assign unused_bits = ^write_data[31:6];

`ifdef IRQ_CTRL_EDGE_EN
    logic [5:0] src_prev;

    assign set_bits = src_irq & ~src_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            src_prev <= '0;
        end else begin
            src_prev <= src_irq;
        end
    end
`else
    assign set_bits = src_irq;
`endif

    // Lowest-numbered active source wins.
    always_comb begin
        sel = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (active[i]) begin
                sel = 3'(i);
            end
        end
    end

    assign ack_clr  = (state == REQ && int_ack) ? (6'b000001 << int_id) : 6'b000000;
    assign clr_bits = ack_clr | (wr_w1c ? write_data[5:0] : 6'b000000);

    always_ff @(posedge clk) begin
        if (rst) begin
            mask    <= '0;
            pending <= '0;
            state   <= IDLE;
            int_req <= 1'b0;
            int_id  <= 3'd0;
        end else begin
            if (wr_mask) begin
                mask <= write_data[5:0];
            end
            // A new set beats a simultaneous W1C or ack clear.
            pending <= (pending & ~clr_bits) | set_bits;

            case (state)
                IDLE: begin
                    if (|active) begin
                        int_id  <= sel;
                        int_req <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (int_ack) begin
                        int_req <= 1'b0;
                        state   <= SVC;
                    end else if (!active[int_id]) begin
                        int_req <= 1'b0;
                        int_id  <= 3'd0;
                        state   <= IDLE;
                    end
                end
                SVC: begin
                    if (wr_eoi) begin
                        int_id <= 3'd0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    int_req <= 1'b0;
                    int_id  <= 3'd0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        case (offset)
            32'h0:   read_result = {26'd0, mask};
            32'h4:   read_result = {26'd0, pending};
            32'h8:   read_result = {(state == SVC), 28'd0, int_id};
            default: read_result = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus randomized traffic against a behavioural model.
// Build with IRQ_CTRL_EDGE_EN defined to check the edge-capture variant.
module tb_irq_ctrl;

    localparam logic [31:0] BASE = 32'h00007f20;
    localparam int P_IDLE = 0;
    localparam int P_REQ  = 1;
    localparam int P_SVC  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = BASE;
    logic        write_enable = 1'b0;
    logic [31:0] write_data = '0;
    logic [31:0] read_result;
    logic [5:0]  src_irq = '0;
    logic        int_req;
    logic [2:0]  int_id;
    logic        int_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit [5:0] m_mask;
    bit [5:0] m_pend;
    bit [5:0] m_prev;
    int       m_phase;
    int       m_id;

    irq_ctrl #(.BASE(BASE)) dut (
        .clk(clk),
        .rst(rst),
        .addr(addr),
        .write_enable(write_enable),
        .write_data(write_data),
        .read_result(read_result),
        .src_irq(src_irq),
        .int_req(int_req),
        .int_id(int_id),
        .int_ack(int_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (off == 32'h0) return {26'd0, m_mask};
        if (off == 32'h4) return {26'd0, m_pend};
        if (off == 32'h8) return {(m_phase == P_SVC), 28'd0, 3'(m_id)};
        return 32'd0;
    endfunction

    // Advances the model by one clock using the inputs the DUT sees at this edge.
    task automatic step_model();
        logic [31:0] off;
        bit [5:0]    act;
        bit [5:0]    nxt;
        int          low;
        bit          fires;
        if (rst) begin
            m_mask = '0; m_pend = '0; m_prev = '0; m_phase = P_IDLE; m_id = 0;
            return;
        end
        off = addr - BASE;
        act = m_pend & m_mask;
        low = -1;
        for (int i = 5; i >= 0; i--) if (act[i]) low = i;
        nxt = m_pend;
        if (write_enable && off == 32'h4) nxt = nxt & ~write_data[5:0];
        if (m_phase == P_REQ && int_ack) nxt[m_id] = 1'b0;
        for (int i = 0; i < 6; i++) begin
`ifdef IRQ_CTRL_EDGE_EN
            fires = src_irq[i] && !m_prev[i];
`else
            fires = src_irq[i];
`endif
            if (fires) nxt[i] = 1'b1;
        end
        if (m_phase == P_IDLE) begin
            if (low >= 0) begin
                m_id = low;
                m_phase = P_REQ;
            end
        end else if (m_phase == P_REQ) begin
            if (int_ack) m_phase = P_SVC;
            else if (!act[m_id]) begin
                m_phase = P_IDLE;
                m_id = 0;
            end
        end else begin
            if (write_enable && off == 32'hC) begin
                m_phase = P_IDLE;
                m_id = 0;
            end
        end
        if (write_enable && off == 32'h0) m_mask = write_data[5:0];
        m_pend = nxt;
        m_prev = src_irq;
    endtask

    task automatic tick();
        @(posedge clk);
        step_model();
        #1;
    endtask

    task automatic bus_write(input logic [31:0] off, input logic [31:0] d);
        addr = BASE + off;
        write_data = d;
        write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
    endtask

    task automatic rd(input logic [31:0] off, output logic [31:0] v);
        addr = BASE + off;
        #1;
        v = read_result;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int o = 0; o < 12; o += 4) begin
            rd(32'(o), v);
            checks++;
            if (v !== 32'd0) begin
                errors++;
                $display("[TB] FAIL reset_read_%0h: got %h expected %h", o, v, 32'd0);
            end
        end
        checks++;
        if (int_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_int_req: got %b expected 0", int_req);
        end
        checks++;
        if (int_id !== 3'd0) begin
            errors++;
            $display("[TB] FAIL reset_int_id: got %0d expected 0", int_id);
        end
    endtask

    task automatic test_single();
        logic [31:0] v;
        bus_write(32'h0, 32'h3F);
        src_irq = 6'b000100;
        tick();
        src_irq = 6'b000000;
        rd(32'h4, v);
        checks++;
        if (v !== 32'h4) begin
            errors++;
            $display("[TB] FAIL single_pending: got %h expected %h", v, 32'h4);
        end
        checks++;
        if (int_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_req_early: got %b expected 0", int_req);
        end
        tick();
        checks++;
        if (int_req !== 1'b1 || int_id !== 3'd2) begin
            errors++;
            $display("[TB] FAIL single_req: got req=%b id=%0d expected req=1 id=2", int_req, int_id);
        end
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        rd(32'h8, v);
        checks++;
        if (v !== 32'h80000002) begin
            errors++;
            $display("[TB] FAIL single_current_svc: got %h expected %h", v, 32'h80000002);
        end
        rd(32'h4, v);
        checks++;
        if (v !== 32'h0 || int_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_after_ack: got pend=%h req=%b expected pend=0 req=0", v, int_req);
        end
        bus_write(32'hC, 32'h0);
        rd(32'h8, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("[TB] FAIL single_current_eoi: got %h expected %h", v, 32'h0);
        end
    endtask

    task automatic test_priority();
        src_irq = 6'b100010;
        tick();
        src_irq = 6'b000000;
        tick();
        checks++;
        if (int_req !== 1'b1 || int_id !== 3'd1) begin
            errors++;
            $display("[TB] FAIL prio_first: got req=%b id=%0d expected req=1 id=1", int_req, int_id);
        end
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        tick();
        checks++;
        if (int_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL prio_no_nesting: got req=%b expected 0", int_req);
        end
        bus_write(32'hC, 32'h0);
        checks++;
        if (int_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL prio_idle_after_eoi: got req=%b expected 0", int_req);
        end
        tick();
        checks++;
        if (int_req !== 1'b1 || int_id !== 3'd5) begin
            errors++;
            $display("[TB] FAIL prio_second: got req=%b id=%0d expected req=1 id=5", int_req, int_id);
        end
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        bus_write(32'hC, 32'h0);
    endtask

    task automatic test_mask_drop();
        logic [31:0] v;
        src_irq = 6'b001000;
        tick();
        src_irq = 6'b000000;
        tick();
        checks++;
        if (int_req !== 1'b1 || int_id !== 3'd3) begin
            errors++;
            $display("[TB] FAIL drop_req: got req=%b id=%0d expected req=1 id=3", int_req, int_id);
        end
        bus_write(32'h0, 32'h37);
        checks++;
        if (int_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL drop_req_held: got req=%b expected 1", int_req);
        end
        tick();
        checks++;
        if (int_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drop_req_gone: got req=%b expected 0", int_req);
        end
        tick();
        tick();
        rd(32'h4, v);
        checks++;
        if (v !== 32'h8 || int_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drop_stays_idle: got pend=%h req=%b expected pend=8 req=0", v, int_req);
        end
        rd(32'h8, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("[TB] FAIL drop_current: got %h expected %h", v, 32'h0);
        end
        bus_write(32'h4, 32'h8);
        bus_write(32'h0, 32'h3F);
    endtask

    task automatic test_hold();
        logic [31:0] v;
        src_irq = 6'b000001;
        tick();
        tick();
        checks++;
        if (int_req !== 1'b1 || int_id !== 3'd0) begin
            errors++;
            $display("[TB] FAIL hold_first: got req=%b id=%0d expected req=1 id=0", int_req, int_id);
        end
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        bus_write(32'hC, 32'h0);
        tick();
        rd(32'h4, v);
`ifdef IRQ_CTRL_EDGE_EN
        checks++;
        if (int_req !== 1'b0 || v !== 32'h0) begin
            errors++;
            $display("[TB] FAIL hold_edge: got req=%b pend=%h expected req=0 pend=0", int_req, v);
        end
`else
        checks++;
        if (int_req !== 1'b1 || int_id !== 3'd0 || v !== 32'h1) begin
            errors++;
            $display("[TB] FAIL hold_level: got req=%b id=%0d pend=%h expected req=1 id=0 pend=1", int_req, int_id, v);
        end
`endif
        src_irq = 6'b000000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset_svc();
        logic [31:0] v;
        bus_write(32'h0, 32'h3F);
        src_irq = 6'b000010;
        tick();
        src_irq = 6'b000000;
        tick();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        rd(32'h8, v);
        checks++;
        if (v !== 32'h80000001) begin
            errors++;
            $display("[TB] FAIL rsvc_in_svc: got %h expected %h", v, 32'h80000001);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int o = 0; o < 12; o += 4) begin
            rd(32'(o), v);
            checks++;
            if (v !== 32'd0) begin
                errors++;
                $display("[TB] FAIL rsvc_read_%0h: got %h expected %h", o, v, 32'd0);
            end
        end
        checks++;
        if (int_req !== 1'b0 || int_id !== 3'd0) begin
            errors++;
            $display("[TB] FAIL rsvc_outputs: got req=%b id=%0d expected req=0 id=0", int_req, int_id);
        end
        bus_write(32'hC, 32'h0);
        rd(32'h8, v);
        checks++;
        if (v !== 32'h0 || int_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rsvc_eoi_ignored: got cur=%h req=%b expected cur=0 req=0", v, int_req);
        end
    endtask

    task automatic test_random();
        logic [31:0] offs [7];
        logic [31:0] exp_rd;
        int op;
        offs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h2, 32'hFFFFFFFC};
        for (int n = 0; n < 600; n++) begin
            src_irq = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'b000000;
            int_ack = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 149) == 0);
            op = $urandom_range(0, 11);
            write_data = $urandom;
            write_enable = 1'b1;
            case (op)
                0: addr = BASE;
                1: addr = BASE + 32'h4;
                2, 3: addr = BASE + 32'hC;
                4: addr = BASE + offs[$urandom_range(4, 6)];
                5: addr = BASE + 32'h8;
                default: begin
                    write_enable = 1'b0;
                    addr = BASE + offs[$urandom_range(0, 6)];
                end
            endcase
            #1;
            exp_rd = m_read(addr);
            checks++;
            if (read_result !== exp_rd) begin
                errors++;
                $display("[TB] FAIL rand_read[%0d]: addr=%h got %h expected %h", n, addr, read_result, exp_rd);
            end
            checks++;
            if (int_req !== (m_phase == P_REQ) || int_id !== 3'(m_id)) begin
                errors++;
                $display("[TB] FAIL rand_out[%0d]: got req=%b id=%0d expected req=%b id=%0d",
                         n, int_req, int_id, (m_phase == P_REQ), m_id);
            end
            tick();
        end
        write_enable = 1'b0;
        int_ack = 1'b0;
        rst = 1'b0;
        src_irq = '0;
    endtask

    initial begin
        m_mask = '0; m_pend = '0; m_prev = '0; m_phase = P_IDLE; m_id = 0;
        test_reset();
        test_single();
        test_priority();
        test_mask_drop();
        test_hold();
        test_reset_svc();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
